// File: rtl/mult8_pkg.sv
// Shared types and widths for the mult8 round-robin scheduler.
package mult8_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

endpackage

// File: rtl/mult8_sched_if.sv
// Requester-side bus of mult8_sched: operand requests in, tagged products out.
interface mult8_sched_if
    import mult8_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) ();

    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][OP_W-1:0] req_a;
    logic [NREQ-1:0][OP_W-1:0] req_b;
    logic [NREQ-1:0]           ack;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [PROD_W-1:0]         rsp_data;
    logic                      rsp_err;

    modport master (
        output req, req_a, req_b,
        input  ack, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req, req_a, req_b,
        output ack, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping mod NREQ.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_idx
);

    // cand[k] is the index visited k+1 steps after ptr
    logic [NREQ-1:0][ID_W-1:0] cand;

    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign cand[k] = ID_W'((int'(ptr) + k + 1) % NREQ);
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_valid && req[cand[k]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/mult8_sched.sv
// Shares one mult8 core among NREQ requesters, round-robin, IDLE->ISSUE->WAIT->RESP.
// Define MULT8_SCHED_TIMEOUT_EN to bound WAIT to TIMEOUT cycles with an error response.
module mult8_sched
    import mult8_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mult8_sched_if.slave      rq,
    output logic              busy,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_ina,
    output logic [OP_W-1:0]   mul_inb,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_out
);

    if (ID_W != $clog2(NREQ)) begin : g_bad_id_w
        $error("mult8_sched: ID_W must equal clog2(NREQ)");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mult8_sched: TIMEOUT must be at least 1");
    end

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [OP_W-1:0]     ina_q, ina_d, inb_q, inb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [PROD_W-1:0]   rsp_data_q, rsp_data_d;
    logic                gnt_valid;
    logic [ID_W-1:0]     gnt_idx;

`ifdef MULT8_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req       (rq.req),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        ina_d       = ina_q;
        inb_d       = inb_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        ack_d       = '0;
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
`ifdef MULT8_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: if (gnt_valid) begin
                state_d = ISSUE;
                gid_d   = gnt_idx;
                ina_d   = rq.req_a[gnt_idx];
                inb_d   = rq.req_b[gnt_idx];
                ack_d   = NREQ'(1) << gnt_idx;
                start_d = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MULT8_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // done on the limit cycle still counts as a normal completion
                if (mul_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mul_out;
                    rsp_id_d    = gid_q;
`ifdef MULT8_SCHED_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_id_d    = gid_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = gid_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NREQ - 1);
            gid_q       <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            ina_q       <= '0;
            inb_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef MULT8_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            ina_q       <= ina_d;
            inb_q       <= inb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef MULT8_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign rq.ack       = ack_q;
    assign rq.rsp_valid = rsp_valid_q;
    assign rq.rsp_id    = rsp_id_q;
    assign rq.rsp_data  = rsp_data_q;
`ifdef MULT8_SCHED_TIMEOUT_EN
    assign rq.rsp_err   = rsp_err_q;
`else
    assign rq.rsp_err   = 1'b0;
`endif
    assign busy         = busy_q;
    assign mul_start    = start_q;
    assign mul_ina      = ina_q;
    assign mul_inb      = inb_q;

endmodule

// File: doc/mult8_sched.md
Name: mult8_sched

Overview:
- Round-robin scheduler that shares one 8-bit shift-add multiplier core among NREQ requesters.
- Captures one requester's operands, pulses the core start, and waits for the core's done.
- Returns the 16-bit product to the granted requester, tagged with the requester's id.
- Sits between the requesting datapaths and the single mult8 instance.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of requester id; must equal clog2(NREQ)
TIMEOUT, 32, WAIT-state cycle limit (used only with MULT8_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; held until matching ack
req_a  in  NREQ*8  operand A, requester i at bits [8i+7:8i]
req_b  in  NREQ*8  operand B, same packing as req_a
ack  out  NREQ  one-hot, one-cycle pulse: operands captured
rsp_valid  out  1  one-cycle pulse: result available
rsp_id  out  ID_W  requester index for the current result
rsp_data  out  16  product
rsp_err  out  1  qualifies rsp_valid; set on timeout
busy  out  1  high in every state except IDLE
mul_start  out  1  one-cycle start pulse to the core
mul_ina  out  8  operand A to the core, held stable from ISSUE to RESP
mul_inb  out  8  operand B to the core, held stable from ISSUE to RESP
mul_done  in  1  core completion strobe
mul_out  in  16  core product, valid when mul_done=1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Round-robin pointer ptr=NREQ-1, so req[0] has first priority.
  - Reset mid-operation abandons the transaction: no ack, no rsp; the core is not notified.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, choose the first set index g searching ptr+1, ptr+2, ... with wrap mod NREQ.
  - Register mul_ina=req_a[g], mul_inb=req_b[g], gid=g.
  - ack[g]=1 on the next cycle, coinciding with ISSUE; go to ISSUE.
  - req bits are sampled only in IDLE. A request dropped before grant is simply not served.
- ISSUE: mul_start=1 for exactly this cycle; ack[gid]=1; go to WAIT.
- WAIT:
  - mul_done is sampled only here; mul_done in any other state is ignored.
  - On mul_done=1, register rsp_data=mul_out, rsp_id=gid, rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1 for one cycle; ptr=gid; go to IDLE.
  - rsp_data and rsp_id hold their values until the next RESP.
- No response backpressure: requesters must accept rsp_valid when it pulses.
- Latency:
  - req high in IDLE at cycle 0 -> ack and mul_start at cycle 1.
  - Earliest mul_done at cycle 2 -> rsp_valid at cycle 3.
  - Next grant decided in IDLE at cycle 4 at the earliest.
- A requester whose req is still high after its ack is treated as a new request. Requesters must drop req in the cycle after ack.
- Multiplication is unsigned; operand 0 is still issued to the core.
- ptr advances only on a completed RESP, including error completions.

Optional Feature:
- Macro: MULT8_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT cycles elapse without mul_done, go to RESP with rsp_data=0, rsp_err=1.
  - mul_done arriving in the same cycle as the limit wins: normal response.
- Undefined:
  - No counter is built; rsp_err is tied to 0.
  - WAIT is unbounded.

Decomposition:
- Package mult8_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - constants OP_W=8, PROD_W=16
- Sub-module rr_arb: NREQ-wide round-robin priority picker.
  - Inputs: req, ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational, instantiated once in the IDLE decision.

Test Plan:
1. Single requester: req[1]=1, a=0x0C, b=0x0A; core model done 9 cycles after start with 0x0078 -> ack[1] pulse, one mul_start, rsp_valid with rsp_id=1, rsp_data=0x0078, rsp_err=0.
2. Round-robin: req=4'b1111 held, each dropped after its ack, then re-raised -> grants in order 0,1,2,3,0; no requester served twice before the others are served.
3. Extremes: a=0xFF, b=0xFF -> rsp_data=0xFE01; a=0x00, b=0x5A -> mul_start still issued, rsp_data=0x0000.
4. Stray done: mul_done pulsed in IDLE and ISSUE -> ignored; the real done in WAIT produces exactly one rsp_valid.
5. Reset mid-WAIT: rst_n=0 two cycles after mul_start -> all outputs 0 immediately, no rsp_valid; the next req[0] is granted first.
6. Timeout (macro defined, TIMEOUT=32): core never asserts done -> rsp_valid exactly 32 cycles after entering WAIT, rsp_err=1, rsp_data=0; without the macro, busy stays 1 indefinitely.
